// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/bubble/flush handling and madd/msub feedback.
// Define HILO_PATH_EN to register the HI/LO path; otherwise those outputs are tied to 0.
module ex_mem #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [RADDR_W-1:0]  ex_rw,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [ALUOP_W-1:0]  ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_reg2,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [RADDR_W-1:0]  mem_rw,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [ALUOP_W-1:0]  mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_reg2,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    logic clear;
    logic bubble;
    logic advance;

    // Only the EX and MEM stall bits matter at this boundary.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    assign clear   = rst || flush;
    assign bubble  = stall[3] && !stall[4];
    assign advance = !stall[3];

    always_ff @(posedge clk) begin
        if (clear || bubble) begin
            mem_rw       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
        end else if (advance) begin
            mem_rw       <= ex_rw;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
        end
    end

`ifdef HILO_PATH_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (bubble) begin
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end else if (advance) begin
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else begin
            // Both stages stalled: MEM holds, EX keeps its partial product alive.
            hilo_o    <= hilo_i;
            cnt_o     <= cnt_i;
        end
    end
`else
    logic unused_hilo;
    assign unused_hilo = ^{ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i};

    assign mem_whilo = 1'b0;
    assign mem_hi    = '0;
    assign mem_lo    = '0;
    assign hilo_o    = '0;
    assign cnt_o     = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed scenarios plus randomized stall/flush traffic
// compared against a behavioural model of the EX->MEM slot.
module tb_ex_mem;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int ALUOP_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [5:0]          stall;
    logic                flush;
    logic [RADDR_W-1:0]  ex_rw;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic                ex_whilo;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [DATA_W-1:0]   ex_mem_addr;
    logic [DATA_W-1:0]   ex_reg2;
    logic [2*DATA_W-1:0] hilo_i;
    logic [1:0]          cnt_i;
    logic [RADDR_W-1:0]  mem_rw;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_whilo;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic [ALUOP_W-1:0]  mem_aluop;
    logic [DATA_W-1:0]   mem_mem_addr;
    logic [DATA_W-1:0]   mem_reg2;
    logic [2*DATA_W-1:0] hilo_o;
    logic [1:0]          cnt_o;

    int checks = 0;
    int errors = 0;

`ifdef HILO_PATH_EN
    localparam bit HILO_EN = 1'b1;
`else
    localparam bit HILO_EN = 1'b0;
`endif

    // What MEM should be looking at: one instruction slot plus the madd feedback.
    typedef struct {
        logic [RADDR_W-1:0]  rw;
        logic                wreg;
        logic [DATA_W-1:0]   wdata;
        logic                whilo;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
        logic [ALUOP_W-1:0]  aluop;
        logic [DATA_W-1:0]   addr;
        logic [DATA_W-1:0]   reg2;
        logic [2*DATA_W-1:0] hilo;
        logic [1:0]          cnt;
    } slot_t;

    slot_t model;

    ex_mem #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_rw(ex_rw), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_rw(mem_rw), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{rw: '0, wreg: 1'b0, wdata: '0, whilo: 1'b0, hi: '0, lo: '0,
              aluop: '0, addr: '0, reg2: '0, hilo: '0, cnt: '0};
        return s;
    endfunction

    // Next contents of the slot, from the current inputs and the present slot.
    function automatic slot_t next_slot(input slot_t cur);
        slot_t n;
        slot_t ex;
        n  = cur;
        ex = '{rw: ex_rw, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo, hi: ex_hi,
               lo: ex_lo, aluop: ex_aluop, addr: ex_mem_addr, reg2: ex_reg2,
               hilo: 64'd0, cnt: 2'd0};
        if (rst || flush) begin
            n = empty_slot();
        end else if (!stall[3]) begin
            n = ex;
        end else begin
            if (!stall[4]) n = empty_slot();
            n.hilo = hilo_i;
            n.cnt  = cnt_i;
        end
        if (!HILO_EN) begin
            n.whilo = 1'b0;
            n.hi    = '0;
            n.lo    = '0;
            n.hilo  = '0;
            n.cnt   = '0;
        end
        return n;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".rw"},    64'(mem_rw),       64'(model.rw));
        check({tag, ".wreg"},  64'(mem_wreg),     64'(model.wreg));
        check({tag, ".wdata"}, 64'(mem_wdata),    64'(model.wdata));
        check({tag, ".whilo"}, 64'(mem_whilo),    64'(model.whilo));
        check({tag, ".hi"},    64'(mem_hi),       64'(model.hi));
        check({tag, ".lo"},    64'(mem_lo),       64'(model.lo));
        check({tag, ".aluop"}, 64'(mem_aluop),    64'(model.aluop));
        check({tag, ".addr"},  64'(mem_mem_addr), 64'(model.addr));
        check({tag, ".reg2"},  64'(mem_reg2),     64'(model.reg2));
        check({tag, ".hilo"},  hilo_o,            model.hilo);
        check({tag, ".cnt"},   64'(cnt_o),        64'(model.cnt));
    endtask

    task automatic randomize_ex();
        ex_rw       = RADDR_W'($urandom);
        ex_wreg     = 1'($urandom);
        ex_wdata    = $urandom;
        ex_whilo    = 1'($urandom);
        ex_hi       = $urandom;
        ex_lo       = $urandom;
        ex_aluop    = ALUOP_W'($urandom_range(1, 255));
        ex_mem_addr = $urandom;
        ex_reg2     = $urandom;
        hilo_i      = {$urandom, $urandom};
        cnt_i       = 2'($urandom);
    endtask

    // Inputs are set at the falling edge, captured on the rising edge, checked at the next fall.
    task automatic step(input string tag);
        @(posedge clk);
        model = next_slot(model);
        @(negedge clk);
        compare_all(tag);
        $display("cyc %s rst=%0b flush=%0b stall=%b mem_rw=%0d mem_wreg=%0b mem_wdata=%h hilo_o=%h cnt_o=%0d",
                 tag, rst, flush, stall, mem_rw, mem_wreg, mem_wdata, hilo_o, cnt_o);
    endtask

    initial begin
        model = empty_slot();
        rst   = 1'b1;
        flush = 1'b0;
        stall = 6'b0;
        randomize_ex();
        ex_wreg = 1'b1;
        ex_whilo = 1'b1;
        cnt_i = 2'd1;
        @(negedge clk);
        step("reset");
        check("reset.wdata_zero", 64'(mem_wdata), 64'd0);
        rst = 1'b0;

        ex_rw = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        step("advance");
        check("advance.rw5", 64'(mem_rw), 64'd5);
        check("advance.wdata", 64'(mem_wdata), 64'h1234_5678);
        check("advance.hilo0", hilo_o, 64'd0);

        randomize_ex();
        stall = 6'b001111;
        step("bubble");
        check("bubble.wreg0", 64'(mem_wreg), 64'd0);
        stall = 6'b000000;
        step("bubble_release");

        randomize_ex();
        step("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            randomize_ex();
            step("hold");
        end
        stall = 6'b0;
        step("hold_release");

        stall  = 6'b001111;
        hilo_i = 64'h0000_0001_FFFF_FFFF;
        cnt_i  = 2'd1;
        step("madd_stall");
        check("madd.hilo", hilo_o, HILO_EN ? 64'h0000_0001_FFFF_FFFF : 64'd0);
        check("madd.cnt", 64'(cnt_o), HILO_EN ? 64'd1 : 64'd0);
        stall = 6'b0;
        step("madd_advance");
        check("madd.hilo_cleared", hilo_o, 64'd0);

        randomize_ex();
        step("pre_flush");
        flush = 1'b1;
        stall = 6'b011111;
        ex_hi = 32'hDEAD;
        step("flush_stall");
        flush = 1'b0;
        stall = 6'b0;
        ex_hi = 32'hDEAD;
        step("hi_path");
        check("hi_path.mem_hi", 64'(mem_hi), HILO_EN ? 64'hDEAD : 64'd0);

        // Madd sequence interrupted by reset.
        stall = 6'b001111; hilo_i = {$urandom, $urandom}; cnt_i = 2'd1;
        step("madd_pre_rst");
        rst = 1'b1;
        step("madd_rst");
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            randomize_ex();
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: stall = 6'b000000;
                4, 5:       stall = 6'b001111;
                6, 7:       stall = 6'b011111;
                default:    stall = 6'($urandom);
            endcase
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 29) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the EX and MEM stages of the five-stage MIPS core. Captures the EX stage's write-back request, HI/LO write request, load/store context (aluop, effective address, store data) and presents them to the MEM stage one cycle later. Honours the pipeline stall vector, inserts bubbles, and flushes on exception. Also holds the intermediate 64-bit product and cycle count for two-cycle multiply-accumulate (madd/msub) instructions while EX is stalled.

## Interface
- DATA_W, 32, general data width (register data, HI, LO, address)
- RADDR_W, 5, register-file address width
- ALUOP_W, 8, aluop code width
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- stall  in  6  pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled
- flush  in  1  exception flush; clears the register
- ex_rw  in  RADDR_W  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  register write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi, ex_lo  in  DATA_W each  HI/LO write data
- ex_aluop  in  ALUOP_W  operation code, used by MEM for load/store decode
- ex_mem_addr  in  DATA_W  load/store effective address
- ex_reg2  in  DATA_W  store data
- hilo_i  in  2*DATA_W  intermediate madd/msub product from EX
- cnt_i  in  2  madd/msub cycle count from EX
- mem_rw, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  same widths as ex_* counterparts  registered values to MEM
- hilo_o  out  2*DATA_W  product fed back to EX
- cnt_o  out  2  cycle count fed back to EX

## Operation
- All outputs are registers; update only on rising clk.
- Clear state: mem_rw=0, mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0, mem_aluop=0 (NOP), mem_mem_addr=0, mem_reg2=0, hilo_o=0, cnt_o=0.
- Per-cycle priority (first match wins):
  - rst=1: clear state.
  - flush=1: clear state (takes precedence over stall).
  - stall[3]=1 and stall[4]=0: bubble; all mem_* outputs take clear values; hilo_o<=hilo_i, cnt_o<=cnt_i.
  - stall[3]=0: advance; every mem_* output <= its ex_* input; hilo_o<=0, cnt_o<=0.
  - otherwise (stall[3]=1, stall[4]=1): hold all mem_* outputs; hilo_o<=hilo_i, cnt_o<=cnt_i.
- stall[3]=0 with stall[4]=1 never occurs by stall-controller contract; the block advances in that case.
- No arithmetic; pure capture. Widths pass through unchanged.

## Timing
- Latency: 1 cycle from ex_* to mem_*.
- Reset and flush take effect at the clock edge they are sampled on; outputs are clear in the following cycle.
- madd/msub: EX asserts stall[3] in cycle N with cnt_i=1 and hilo_i=partial product; in cycle N+1, hilo_o/cnt_o present those values to EX; on advance they return to 0 the following cycle.
- Reset or flush in the middle of a madd sequence discards hilo_o/cnt_o (both 0).
- Bubble for one stall cycle yields exactly one cycle of NOP on mem_*; the original instruction is not lost, because EX holds it.

## Configuration
- Macro HILO_PATH_EN.
- Defined: ex_whilo/ex_hi/ex_lo, mem_whilo/mem_hi/mem_lo, hilo_i/cnt_i and hilo_o/cnt_o are registered exactly as above.
- Undefined: the ports remain present; mem_whilo, mem_hi, mem_lo, hilo_o and cnt_o are tied to 0, and their inputs are ignored. This is for cores built without mult/div/madd support.

## Test plan
- Reset: drive rst=1 with every ex_* input at a nonzero value -> all outputs are 0 after the edge.
- Advance: stall=0, ex_rw=5, ex_wreg=1, ex_wdata=0x12345678 -> next cycle mem_rw=5, mem_wreg=1, mem_wdata=0x12345678; hilo_o=0.
- Bubble: stall=6'b001111 with valid ex_* inputs -> mem_wreg=0, mem_aluop=0, mem_wdata=0 for one cycle. Then stall=0 -> the inputs propagate.
- Hold: load a value, then stall=6'b011111 for 3 cycles while ex_* inputs change -> mem_* outputs stay unchanged.
- madd: stall=6'b001111, hilo_i=0x00000001_FFFFFFFF, cnt_i=1 -> next cycle hilo_o=0x00000001_FFFFFFFF, cnt_o=1. Then stall=0 -> hilo_o=0, cnt_o=0 the following cycle.
- Flush vs stall: flush=1 together with stall=6'b011111 -> all outputs clear. Without HILO_PATH_EN, ex_hi=0xDEAD -> mem_hi stays 0.
